// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline stall/flush scheduler.
// Purely declarative: no latency, no flow control.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_ADDR = 2'd1;
  localparam logic [1:0] D_DATA = 2'd2;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic refresh_id;
    logic refresh_ex;
    logic refresh_mem;
    logic refresh_wb;
  } seg_ctrl_t;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage read of a GPR that the load in EX has not yet produced.
// Combinational, zero latency; no flow control of its own.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_ren,
  input  logic             id_rt_ren,
  input  logic             ex_load,
  input  logic             ex_regwen,
  input  logic [REG_W-1:0] ex_wreg,
  output logic             lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_rs_ren & (id_rs == ex_wreg);
  assign rt_hit = id_rt_ren & (id_rt == ex_wreg);

  // $zero is never a real dependency.
  assign lu = ex_load & ex_regwen & (ex_wreg != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/refresh scheduler for the four segment registers; outputs are combinational from state plus inputs.
// Bus waits stall everything up to MEM; flushes wait for the data bus so no response is orphaned.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_ren,
  input  logic       id_rt_ren,
  input  logic       ex_load,
  input  logic       ex_regwen,
  input  logic [4:0] ex_wreg,
  input  logic       ex_div_start,
  input  logic       if_inst_addr_ok,
  input  logic       if_inst_data_ok,
  input  logic       mem_data_req,
  input  logic       mem_data_addr_ok,
  input  logic       mem_data_data_ok,
  input  logic       exc_valid,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       refresh_id,
  output logic       refresh_ex,
  output logic       refresh_mem,
  output logic       refresh_wb,
  output logic       inst_discard,
  output logic       div_busy
);

  localparam int              CW       = clog2(DIV_CYCLES);
  localparam logic [CW-1:0]   DIV_LOAD = CW'(DIV_CYCLES - 1);

  logic [1:0]    dstate;
  logic [1:0]    dstate_nxt;
  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_cnt_nxt;
  logic          inst_out;
  logic          inst_out_nxt;
  logic          discard;
  logic          discard_nxt;

  logic          ifetch_wait;
  logic          dwait;
  logic          flush;
  logic          lu;
  logic          cnt_nz;
  seg_ctrl_t     ctl;

  load_use_detect u_lu (
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rs_ren (id_rs_ren),
    .id_rt_ren (id_rt_ren),
    .ex_load   (ex_load),
    .ex_regwen (ex_regwen),
    .ex_wreg   (ex_wreg),
    .lu        (lu)
  );

  assign cnt_nz      = (div_cnt != '0);
  assign ifetch_wait = inst_out & ~if_inst_data_ok;
  assign dwait       = ((dstate != D_IDLE) | mem_data_req)
                     & ~((dstate == D_DATA) & mem_data_data_ok);
  // An exception is only honoured once the data bus is quiet.
  assign flush       = exc_valid & ~dwait;

  always_comb begin
    dstate_nxt = dstate;
    case (dstate)
      D_IDLE: begin
        if (mem_data_req) dstate_nxt = mem_data_addr_ok ? D_DATA : D_ADDR;
      end
      D_ADDR: begin
        if (mem_data_addr_ok) dstate_nxt = D_DATA;
      end
      D_DATA: begin
        if (mem_data_data_ok) dstate_nxt = D_IDLE;
      end
      default: dstate_nxt = D_IDLE;
    endcase
  end

  always_comb begin
    inst_out_nxt = inst_out;
    if (if_inst_addr_ok)      inst_out_nxt = 1'b1;
    else if (if_inst_data_ok) inst_out_nxt = 1'b0;
  end

  // A flush with a fetch in flight marks that response as stale.
  always_comb begin
    discard_nxt = discard;
    if (flush & ifetch_wait)  discard_nxt = 1'b1;
    else if (if_inst_data_ok) discard_nxt = 1'b0;
  end

  // The divider holds while the data bus keeps the whole pipe frozen.
  always_comb begin
    div_cnt_nxt = div_cnt;
    if (flush)                div_cnt_nxt = '0;
    else if (ex_div_start)    div_cnt_nxt = DIV_LOAD;
    else if (cnt_nz & ~dwait) div_cnt_nxt = div_cnt - CW'(1);
  end

  always_comb begin
    ctl = '0;
    if (reset) begin
      ctl = '0;
    end else if (flush) begin
      ctl.refresh_id  = 1'b1;
      ctl.refresh_ex  = 1'b1;
      ctl.refresh_mem = 1'b1;
      ctl.refresh_wb  = 1'b1;
    end else if (dwait) begin
      ctl.stall_if   = 1'b1;
      ctl.stall_id   = 1'b1;
      ctl.stall_ex   = 1'b1;
      ctl.stall_mem  = 1'b1;
      ctl.refresh_wb = 1'b1;
    end else if (cnt_nz) begin
      ctl.stall_if    = 1'b1;
      ctl.stall_id    = 1'b1;
      ctl.stall_ex    = 1'b1;
      ctl.refresh_mem = 1'b1;
    end else if (lu) begin
      ctl.stall_if   = 1'b1;
      ctl.stall_id   = 1'b1;
      ctl.refresh_ex = 1'b1;
    end else if (ifetch_wait) begin
      ctl.stall_if   = 1'b1;
      ctl.refresh_id = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dstate   <= D_IDLE;
      div_cnt  <= '0;
      inst_out <= 1'b0;
      discard  <= 1'b0;
    end else begin
      dstate   <= dstate_nxt;
      div_cnt  <= div_cnt_nxt;
      inst_out <= inst_out_nxt;
      discard  <= discard_nxt;
    end
  end

  assign stall_if     = ctl.stall_if;
  assign stall_id     = ctl.stall_id;
  assign stall_ex     = ctl.stall_ex;
  assign stall_mem    = ctl.stall_mem;
  assign refresh_id   = ctl.refresh_id;
  assign refresh_ex   = ctl.refresh_ex;
  assign refresh_mem  = ctl.refresh_mem;
  assign refresh_wb   = ctl.refresh_wb;
  assign inst_discard = discard & ~reset;
  assign div_busy     = cnt_nz & ~reset;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed test-plan scenarios followed by random traffic, all checked
// cycle by cycle against a transaction-level model of the scheduler.
module tb_pipe_ctrl;

  localparam int DIVC = 33;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_wreg;
  logic id_rs_ren, id_rt_ren, ex_load, ex_regwen, ex_div_start;
  logic if_inst_addr_ok, if_inst_data_ok;
  logic mem_data_req, mem_data_addr_ok, mem_data_data_ok, exc_valid;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic refresh_id, refresh_ex, refresh_mem, refresh_wb;
  logic inst_discard, div_busy;

  always #5 clk = ~clk;

  pipe_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren),
    .ex_load(ex_load), .ex_regwen(ex_regwen), .ex_wreg(ex_wreg),
    .ex_div_start(ex_div_start),
    .if_inst_addr_ok(if_inst_addr_ok), .if_inst_data_ok(if_inst_data_ok),
    .mem_data_req(mem_data_req), .mem_data_addr_ok(mem_data_addr_ok),
    .mem_data_data_ok(mem_data_data_ok), .exc_valid(exc_valid),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .refresh_id(refresh_id), .refresh_ex(refresh_ex), .refresh_mem(refresh_mem),
    .refresh_wb(refresh_wb), .inst_discard(inst_discard), .div_busy(div_busy)
  );

  // {stall_if,id,ex,mem, refresh_id,ex,mem,wb, inst_discard, div_busy}
  logic [9:0] dut_vec;
  assign dut_vec = {stall_if, stall_id, stall_ex, stall_mem,
                    refresh_id, refresh_ex, refresh_mem, refresh_wb,
                    inst_discard, div_busy};

  int n_chk = 0;
  int n_err = 0;
  logic [9:0] last_vec;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: transaction-level bookkeeping of what is in flight.
  bit mdl_fetch_pending;
  bit mdl_drop_next_fetch;
  bit mdl_need_addr_accept;
  bit mdl_need_data;
  int mdl_div_left;

  function automatic bit mdl_bus_blocked();
    bit busy;
    busy = mdl_need_addr_accept || mdl_need_data || mem_data_req;
    if (mdl_need_data && mem_data_data_ok) busy = 0;
    return busy;
  endfunction

  function automatic bit mdl_hazard();
    if (!(ex_load && ex_regwen) || ex_wreg == 0) return 0;
    return (id_rs_ren && id_rs == ex_wreg) || (id_rt_ren && id_rt == ex_wreg);
  endfunction

  function automatic logic [9:0] mdl_expect();
    logic [9:0] v;
    bit fetch_wait;
    if (reset) return '0;
    fetch_wait = mdl_fetch_pending && !if_inst_data_ok;
    if (exc_valid && !mdl_bus_blocked())  v = 10'b0000_1111_00;
    else if (mdl_bus_blocked())           v = 10'b1111_0001_00;
    else if (mdl_div_left > 0)            v = 10'b1110_0010_00;
    else if (mdl_hazard())                v = 10'b1100_0100_00;
    else if (fetch_wait)                  v = 10'b1000_1000_00;
    else                                  v = '0;
    v[1] = mdl_drop_next_fetch;
    v[0] = (mdl_div_left > 0);
    return v;
  endfunction

  function automatic void mdl_step();
    bit blocked, flushing, fetch_wait;
    if (reset) begin
      mdl_fetch_pending = 0; mdl_drop_next_fetch = 0;
      mdl_need_addr_accept = 0; mdl_need_data = 0; mdl_div_left = 0;
      return;
    end
    blocked    = mdl_bus_blocked();
    flushing   = exc_valid && !blocked;
    fetch_wait = mdl_fetch_pending && !if_inst_data_ok;
    if (flushing && fetch_wait) mdl_drop_next_fetch = 1;
    else if (if_inst_data_ok)   mdl_drop_next_fetch = 0;
    if (if_inst_addr_ok)        mdl_fetch_pending = 1;
    else if (if_inst_data_ok)   mdl_fetch_pending = 0;
    if (mdl_need_data) begin
      if (mem_data_data_ok) mdl_need_data = 0;
    end else if (mdl_need_addr_accept) begin
      if (mem_data_addr_ok) begin mdl_need_addr_accept = 0; mdl_need_data = 1; end
    end else if (mem_data_req) begin
      if (mem_data_addr_ok) mdl_need_data = 1;
      else                  mdl_need_addr_accept = 1;
    end
    if (flushing)                         mdl_div_left = 0;
    else if (ex_div_start)                mdl_div_left = DIVC - 1;
    else if (mdl_div_left > 0 && !blocked) mdl_div_left--;
  endfunction

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_wreg = '0;
    id_rs_ren = 0; id_rt_ren = 0; ex_load = 0; ex_regwen = 0; ex_div_start = 0;
    if_inst_addr_ok = 0; if_inst_data_ok = 0;
    mem_data_req = 0; mem_data_addr_ok = 0; mem_data_data_ok = 0; exc_valid = 0;
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    last_vec = dut_vec;
    chk(tag, 32'(dut_vec), 32'(mdl_expect()));
    @(posedge clk);
    mdl_step();
    #1;
  endtask

  int n;
  bit exc_hold;

  initial begin
    mdl_fetch_pending = 0; mdl_drop_next_fetch = 0;
    mdl_need_addr_accept = 0; mdl_need_data = 0; mdl_div_left = 0;
    clear_inputs();
    reset = 1;
    cycle("reset0");
    cycle("reset1");
    reset = 0;
    cycle("idle");
    chk("rst_out", 32'(last_vec), 32'h0);

    // Load-use: one bubble, then nothing; $zero destination never stalls.
    ex_load = 1; ex_regwen = 1; ex_wreg = 5'd5; id_rs = 5'd5; id_rs_ren = 1;
    cycle("lu");
    chk("lu_vec", 32'(last_vec), 32'(10'b1100_0100_00));
    clear_inputs();
    cycle("lu_after");
    chk("lu_after_vec", 32'(last_vec), 32'h0);
    ex_load = 1; ex_regwen = 1; ex_wreg = 5'd0; id_rs = 5'd0; id_rs_ren = 1;
    cycle("lu_r0");
    chk("lu_r0_vec", 32'(last_vec), 32'h0);
    clear_inputs();

    // Divide occupancy.
    ex_div_start = 1;
    cycle("div_start");
    ex_div_start = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cycle("div");
      if (last_vec[0]) begin
        n++;
        if (n == 1) chk("div_vec", 32'(last_vec), 32'(10'b1110_0010_01));
      end else break;
    end
    chk("div_len", n, DIVC - 1);

    // Data wait: addr_ok after 2 cycles, data_ok 3 cycles later.
    n = 0;
    mem_data_req = 1;
    for (int i = 0; i < 6; i++) begin
      mem_data_addr_ok = (i == 2);
      mem_data_data_ok = (i == 5);
      if (i == 5) mem_data_req = 0;
      cycle("dwait");
      if (last_vec[6]) n++;
    end
    chk("dwait_len", n, 5);
    chk("dwait_release", 32'(last_vec), 32'h0);
    clear_inputs();
    cycle("dwait_idle");
    chk("dwait_idle_vec", 32'(last_vec), 32'h0);

    // Exception while an instruction fetch is outstanding.
    if_inst_addr_ok = 1;
    cycle("fetch_req");
    if_inst_addr_ok = 0; exc_valid = 1;
    cycle("exc_fetch");
    chk("exc_fetch_vec", 32'(last_vec), 32'(10'b0000_1111_00));
    exc_valid = 0;
    cycle("discard_wait");
    chk("discard_wait_vec", 32'(last_vec), 32'(10'b1000_1000_10));
    if_inst_data_ok = 1;
    cycle("discard_ret");
    chk("discard_ret_vec", 32'(last_vec), 32'(10'b0000_0000_10));
    if_inst_data_ok = 0;
    cycle("discard_clr");
    chk("discard_clr_vec", 32'(last_vec), 32'h0);

    // Exception held during a data wait is deferred to the data_ok cycle.
    mem_data_req = 1; mem_data_addr_ok = 1;
    cycle("d_req");
    mem_data_req = 0; mem_data_addr_ok = 0; exc_valid = 1;
    cycle("exc_dwait0");
    chk("exc_dwait_vec", 32'(last_vec), 32'(10'b1111_0001_00));
    cycle("exc_dwait1");
    mem_data_data_ok = 1;
    cycle("exc_dflush");
    chk("exc_dflush_vec", 32'(last_vec), 32'(10'b0000_1111_00));
    clear_inputs();
    cycle("exc_dafter");

    // Exception during divide clears the counter.
    ex_div_start = 1;
    cycle("div2_start");
    ex_div_start = 0;
    for (int i = 0; i < 4; i++) cycle("div2");
    exc_valid = 1;
    cycle("div2_exc");
    chk("div_exc_vec", 32'(last_vec), 32'(10'b0000_1111_01));
    exc_valid = 0;
    cycle("div2_after");
    chk("div_exc_after", 32'(last_vec), 32'h0);

    // Reset when the counter has reached 10.
    ex_div_start = 1;
    cycle("div3_start");
    ex_div_start = 0;
    for (int i = 0; i < DIVC - 11; i++) cycle("div3");
    chk("div3_cnt", mdl_div_left, 10);
    reset = 1;
    cycle("div3_reset");
    reset = 0;
    cycle("div3_post");
    chk("reset_mid_div", 32'(last_vec), 32'h0);

    // Random protocol-legal traffic.
    exc_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_wreg = 5'($urandom_range(0, 3));
      id_rs_ren = 1'($urandom_range(0, 1));
      id_rt_ren = 1'($urandom_range(0, 1));
      ex_load = 1'($urandom_range(0, 1));
      ex_regwen = 1'($urandom_range(0, 3) != 0);
      if_inst_data_ok = mdl_fetch_pending && ($urandom_range(0, 2) == 0);
      if_inst_addr_ok = (!mdl_fetch_pending || if_inst_data_ok) && ($urandom_range(0, 2) == 0);
      mem_data_req = ($urandom_range(0, 4) == 0);
      mem_data_addr_ok = (mem_data_req || mdl_need_addr_accept) && ($urandom_range(0, 1) == 0);
      mem_data_data_ok = mdl_need_data && ($urandom_range(0, 2) == 0);
      ex_div_start = (mdl_div_left == 0) && ($urandom_range(0, 59) == 0);
      exc_valid = exc_hold || ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 799) == 0);
      exc_hold = exc_valid && mdl_bus_blocked() && !reset;
      cycle("rand");
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
